// File: rtl/instr_encoder_if.sv
// Request/word stream bundle for instr_encoder. Each side's transfer happens on a clock edge
// where valid && ready are both high. Once valid is raised, the payload holds until ready.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [2:0]  in_alu;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic [7:0]  err_count;

    modport slave (
        input  in_valid, in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_data, out_addr, err_count
    );

    modport master (
        output in_valid, in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_data, out_addr, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes instruction requests into MIPS words, buffers them in a FIFO and emits them
// with a running byte address. Invalid requests are accepted, dropped and counted.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    instr_encoder_if.slave   bus
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_addr;
    logic [7:0]    r_err;

    logic [31:0] w_word;
    logic [5:0]  w_funct;
    logic        w_req_ok;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_funct  = 6'b000000;
        w_word   = 32'h0000_0000;
        w_req_ok = 1'b0;
        case (bus.in_alu)
            3'd0:    w_funct = 6'b100000;
            3'd1:    w_funct = 6'b100010;
            3'd2:    w_funct = 6'b100100;
            3'd3:    w_funct = 6'b100101;
            3'd4:    w_funct = 6'b101010;
            default: w_funct = 6'b000000;
        endcase
        case (bus.in_kind)
            3'd0: begin
                w_word   = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, w_funct};
                w_req_ok = (bus.in_alu <= 3'd4);
            end
            3'd1: begin
                w_word   = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
                w_req_ok = 1'b1;
            end
            3'd2: begin
                w_word   = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
                w_req_ok = 1'b1;
            end
            3'd3: begin
                w_word   = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
                w_req_ok = 1'b1;
            end
            3'd4: begin
                w_word   = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
                w_req_ok = 1'b1;
            end
            3'd5: begin
                w_word   = {6'b000010, bus.in_target};
                w_req_ok = 1'b1;
            end
            default: begin
                w_word   = 32'h0000_0000;
                w_req_ok = 1'b0;
            end
        endcase
    end

    // No bypass: a full FIFO refuses requests even in a cycle where it pops.
    assign bus.in_ready  = (r_count != L_FULL);
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_addr  = r_addr;
    assign bus.err_count = r_err;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_push   = w_accept && w_req_ok;
    assign w_pop    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
            r_err    <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept && !w_req_ok && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes structured instruction requests (kind, registers, ALU operation, immediate, jump target) into 32-bit MIPS machine words. It is the inverse of the control-unit decode path, covering the same opcode set: R-type, lw, sw, beq, bne and j. Encoded words are buffered in a small FIFO and emitted with a running byte address, ready to be written into instruction memory by a loader or testbench. Unsupported requests are consumed, dropped and counted.

## Interface
- DEPTH, 4: FIFO entries; a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address assigned to the first emitted word.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_kind  in  3  request kind:
  - 0 = R-type, 1 = lw, 2 = sw, 3 = beq, 4 = bne, 5 = j.
  - 6 and 7 are invalid.
- in_alu  in  3  R-type function: 0 add, 1 sub, 2 and, 3 or, 4 slt; 5–7 are invalid.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate for lw, sw, beq and bne.
- in_target  in  26  jump target field.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  32  encoded instruction.
- out_addr  out  32  byte address of out_data.
- err_count  out  8  count of dropped invalid requests; saturates at 255.

## Operation
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}.
    - funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw: {100011, rs, rt, imm}.
  - sw: {101011, rs, rt, imm}.
  - beq: {000100, rs, rt, imm}.
  - bne: {000101, rs, rt, imm}.
  - j: {000010, target}.
  - Fields not used by a kind are ignored.
- Invalid request: kind 6 or 7, or kind 0 with in_alu 5–7.
  - The request is still accepted when in_ready is high.
  - It is not pushed into the FIFO.
  - err_count increments by 1, saturating at 255.
- FIFO:
  - Circular buffer with DEPTH entries.
  - Read and write pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
- in_ready = (count != DEPTH). There is no bypass, so in_ready stays low when full even if a pop happens in the same cycle.
- Push occurs on in_valid && in_ready && request valid.
- Pop occurs on out_valid && out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- out_valid = (count != 0).
- out_data is the FIFO head.
- Address counter:
  - out_addr is a register, reset to BASE_ADDR.
  - It advances by 4 on every pop.
  - It wraps modulo 2^32.
  - Dropped requests do not consume an address.
- While out_valid is high and out_ready is low, out_data and out_addr hold stable.

## Timing
- Reset (asynchronous, takes effect immediately):
  - count = 0, pointers = 0, out_valid = 0, in_ready = 1.
  - out_addr = BASE_ADDR, err_count = 0.
  - out_data is undefined while out_valid = 0.
- Reset mid-operation discards every buffered word. The first word after reset is at BASE_ADDR again.
- Latency: a request accepted at edge N appears on out_data with out_valid = 1 after edge N, i.e. during cycle N+1.
- Throughput: one request per cycle and one word per cycle, sustained while the FIFO is neither full nor empty.
- Full FIFO with out_ready held low: in_ready = 0, and in_valid is ignored.
- Empty FIFO with out_ready = 1: no pop occurs and out_addr is unchanged.
- err_count updates on the accepting edge; at 255 it holds at 255.

## Test plan
- Reset, then push R-type add with rs=1, rt=2, rd=3 and out_ready=1:
  - Next cycle: out_data=32'h0022_1820, out_addr=0.
  - After the pop: out_valid=0, out_addr=4.
- Back-to-back lw (rs=29, rt=8, imm=4), sw (rs=29, rt=8, imm=8), beq (rs=1, rt=0, imm=16'hFFFF) and j (target=26'h40), with out_ready=1:
  - Expected words: 32'h8FA8_0004, 32'hAFA8_0008, 32'h1020_FFFF, 32'h0800_0040.
  - Expected addresses: 0, 4, 8, 12.
- Hold out_ready=0 and push 5 valid requests:
  - in_ready drops after the 4th acceptance; the 5th is held until a pop.
  - Raise out_ready: all 5 words emerge in order with contiguous addresses.
- Push kind=6, then R-type with in_alu=7, then a valid add:
  - err_count=2.
  - Only the add is emitted, at out_addr=0.
- Push 300 invalid requests: err_count saturates at 255.
- Fill 2 entries, assert rst for part of a cycle:
  - out_valid=0, in_ready=1 immediately.
  - The next push emits at BASE_ADDR.
  - Repeat with BASE_ADDR=32'hFFFF_FFFC: the second word wraps to address 0.
